// File: rtl/parity_frame_tx_pkg.sv
// Shared types and defaults for the parity framing transmitter: FSM state encoding
// and the rule that picks the frame parity bit from the hc280 sigma outputs.
package parity_frame_tx_pkg;

  localparam int DEFAULT_DATA_W    = 9;
  localparam int DEFAULT_BAUD_DIV  = 4;
  localparam int DEFAULT_STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Even frame parity repeats sigma_odd; odd frame parity repeats sigma_even.
  function automatic logic frame_parity(input logic odd_sel,
                                        input logic sigma_even,
                                        input logic sigma_odd);
    return odd_sel ? sigma_even : sigma_odd;
  endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Upstream word handshake into the framing transmitter: counter word, hc280 sigma pair,
// parity mode and valid/ready.
interface parity_frame_tx_if #(
  parameter int DATA_W = parity_frame_tx_pkg::DEFAULT_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              sigma_even;
  logic              sigma_odd;
  logic              odd_sel;

  modport master (
    output in_valid, data_in, sigma_even, sigma_odd, odd_sel,
    input  in_ready
  );

  modport slave (
    input  in_valid, data_in, sigma_even, sigma_odd, odd_sel,
    output in_ready
  );
endinterface

// File: rtl/parity_frame_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1, pulses tick on the last count, and is
// re-phased by restart so the first bit of a frame gets a full period.
module baud_tick_gen #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart,
  output logic tick
);
  localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial framing transmitter: start bit, DATA_W data bits LSB first, parity bit taken
// from the hc280 sigma pair, then STOP_BITS stop bits on a line that idles high.
module parity_frame_tx
  import parity_frame_tx_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
  input  logic                clk,
  input  logic                clr_n,
  parity_frame_tx_if.slave    in_if,
  output logic                tx_out,
  output logic                busy,
  output logic                done,
  output logic                sigma_err
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_q,   bit_d;
  logic [SW-1:0]     stop_q,  stop_d;
  logic              par_q,   par_d;
  logic              err_q,   err_d;
  logic              accept;
  logic              tick;

  assign in_if.in_ready = (state_q == ST_IDLE);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign busy           = (state_q != ST_IDLE);
  assign sigma_err      = err_q;

  baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk     (clk),
    .clr_n   (clr_n),
    .restart (accept),
    .tick    (tick)
  );

  // NOTE: every variable driven here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;
    err_d   = err_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          shreg_d = in_if.data_in;
          par_d   = frame_parity(in_if.odd_sel, in_if.sigma_even, in_if.sigma_odd);
          bit_d   = '0;
          stop_d  = '0;
          if (in_if.sigma_even == in_if.sigma_odd) err_d = 1'b1;
        end
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BW'(DATA_W - 1)) state_d = ST_PARITY;
          else                          bit_d   = bit_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          stop_d  = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_q == SW'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_out = 1'b1;
    case (state_q)
      ST_START:  tx_out = 1'b0;
      ST_DATA:   tx_out = shreg_q[0];
      ST_PARITY: tx_out = par_q;
      default:   tx_out = 1'b1;
    endcase
  end

  // NOTE: state updates use <= so every register samples pre-edge values; the shift
  // register is a plain register, not a memory, so it is cleared along with the rest.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      stop_q  <= '0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

endmodule
